// File: rtl/s38584_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s38584_arb_pkg
// Brief    : Shared constants, FSM state type and channel index map for the
//            s38584 channel arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package s38584_arb_pkg;

  localparam int NUM_REQ_DEF = 10;
  localparam int ID_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Channel index of each s38584 request flag within req[]
  localparam int CH_G5124 = 0;
  localparam int CH_G5471 = 1;
  localparam int CH_G5817 = 2;
  localparam int CH_G6163 = 3;
  localparam int CH_G6509 = 4;
  localparam int CH_G3466 = 5;
  localparam int CH_G3115 = 6;
  localparam int CH_G3817 = 7;
  localparam int CH_G4420 = 8;
  localparam int CH_G4427 = 9;

endpackage
`default_nettype wire

// File: rtl/s38584_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : s38584_rr_pick
// Brief    : Combinational rotating priority encoder. Returns the first set
//            request bit at or after ptr, scanning upward with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module s38584_rr_pick #(
  parameter int NUM_REQ = 10,
  parameter int ID_W    = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    win,
  output logic               any
);

  int idx;

  // Scan farthest offset first so the nearest set bit to ptr is written last
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req[idx]) begin
        win = ID_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/s38584_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : s38584_chan_arbiter
// Brief    : Registered round-robin arbiter granting one of the ten s38584
//            channel request flags per service slot, gated by g35.
//            Optional forced release after TIMEOUT grant cycles is enabled
//            by defining S38584_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module s38584_chan_arbiter
  import s38584_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               g35,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               excl_ok,
  output logic               timeout
);

  // Reject configurations the index and counter logic cannot represent
  if (ID_W < $clog2(NUM_REQ) || TIMEOUT < 1) begin : g_cfg_check
    $error("s38584_chan_arbiter: unsupported NUM_REQ/ID_W/TIMEOUT");
  end

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               excl_ok_q, excl_ok_d;
  logic               timeout_q, timeout_d;

  logic [ID_W-1:0]    pick_win;
  logic               pick_any;
  logic               norm_exit;
  logic               tmo_hit;
  logic [ID_W-1:0]    ptr_next;

  s38584_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

`ifdef S38584_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Grant-age counter: held at zero outside GRANT so it is clear on entry
  always_comb begin
    cnt_d   = '0;
    tmo_hit = 1'b0;
    if (state_q == GRANT) begin
      cnt_d   = cnt_q + CNT_W'(1);
      tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  end

  // Grant-age counter register
  always_ff @(posedge CK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the timeout feature a grant is only ended by its owner or g35
  assign tmo_hit = 1'b0;
`endif

  // Release conditions of the current grant and the pointer after it
  always_comb begin
    norm_exit = done | ~req[gnt_id_q] | ~g35;
    if (gnt_id_q == ID_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = gnt_id_q + ID_W'(1);
    end
  end

  // Next-state and registered-output logic of the arbitration FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    excl_ok_d = ((gnt_q & (gnt_q - NUM_REQ'(1))) == '0);
    case (state_q)
      IDLE: begin
        if (g35 && pick_any) begin
          state_d  = GRANT;
          gnt_d    = NUM_REQ'(1) << pick_win;
          gnt_id_d = pick_win;
          busy_d   = 1'b1;
        end
      end
      GRANT: begin
        if (norm_exit || tmo_hit) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          busy_d    = 1'b0;
          ptr_d     = ptr_next;
          // A normal exit in the same cycle hides the forced release
          timeout_d = tmo_hit & ~norm_exit;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      excl_ok_q <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      excl_ok_q <= excl_ok_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign excl_ok = excl_ok_q;
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_s38584_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_s38584_chan_arbiter
// Brief    : Directed, table-driven bench for s38584_chan_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s38584_chan_arbiter;

  logic       CK;
  logic       RST;
  logic       g35;
  logic [9:0] req;
  logic       done;
  logic [9:0] gnt;
  logic [3:0] gnt_id;
  logic       busy;
  logic       excl_ok;
  logic       timeout;

  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic       g35;
    logic [9:0] req;
    logic       done;
    logic [9:0] gnt;
    logic [3:0] id;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  s38584_chan_arbiter dut (
    .CK      (CK),
    .RST     (RST),
    .g35     (g35),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .excl_ok (excl_ok),
    .timeout (timeout)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  function automatic void add(input logic rst, input logic en, input logic [9:0] rq,
                              input logic dn, input logic [9:0] eg, input logic [3:0] eid,
                              input logic eb);
    vec_t v;
    v.rst = rst; v.g35 = en; v.req = rq; v.done = dn;
    v.gnt = eg; v.id = eid; v.busy = eb; v.tmo = 1'b0;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector away from the edge, then compare after the edge
  task automatic step(input vec_t v, input string tag);
    @(negedge CK);
    RST = v.rst; g35 = v.g35; req = v.req; done = v.done;
    @(posedge CK);
    #1;
    chk({tag, " gnt"},     32'(gnt),     32'(v.gnt));
    chk({tag, " gnt_id"},  32'(gnt_id),  32'(v.id));
    chk({tag, " busy"},    32'(busy),    32'(v.busy));
    chk({tag, " timeout"}, 32'(timeout), 32'(v.tmo));
    chk({tag, " excl_ok"}, 32'(excl_ok), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    RST = 1'b1; g35 = 1'b0; req = '0; done = 1'b0;

    // Reset for two cycles
    add(1, 0, 10'h000, 0, 10'h000, 0, 0);
    add(1, 0, 10'h000, 0, 10'h000, 0, 0);
    // Single request g5124: grant next cycle, done releases, ptr -> 1
    add(0, 1, 10'h001, 0, 10'h001, 0, 1);
    add(0, 1, 10'h001, 1, 10'h000, 0, 0);
    add(0, 1, 10'h000, 0, 10'h000, 0, 0);
    // All requests held, done always high: ids 1..9,0,1 with gaps; ptr -> 2
    for (int k = 0; k < 11; k++) begin
      int id;
      id = (1 + k) % 10;
      add(0, 1, 10'h3FF, 1, 10'(1) << id, 4'(id), 1);
      add(0, 1, 10'h3FF, 1, 10'h000, 0, 0);
      add(0, 1, 10'h3FF, 1, 10'h000, 0, 0);
    end
    // Grant 8 to move ptr to 9, then req 0x201: id 9 then wrap to id 0
    add(0, 1, 10'h100, 0, 10'h100, 8, 1);
    add(0, 1, 10'h100, 1, 10'h000, 0, 0);
    add(0, 1, 10'h000, 0, 10'h000, 0, 0);
    add(0, 1, 10'h201, 0, 10'h200, 9, 1);
    add(0, 1, 10'h201, 1, 10'h000, 0, 0);
    add(0, 1, 10'h201, 0, 10'h000, 0, 0);
    add(0, 1, 10'h201, 0, 10'h001, 0, 1);
    add(0, 1, 10'h201, 1, 10'h000, 0, 0);
    add(0, 1, 10'h000, 0, 10'h000, 0, 0);
    // Grant id 3, drop g35: release, blocked while low, regrant on g35=1
    add(0, 1, 10'h008, 0, 10'h008, 3, 1);
    add(0, 0, 10'h008, 0, 10'h000, 0, 0);
    add(0, 0, 10'h008, 0, 10'h000, 0, 0);
    add(0, 0, 10'h008, 0, 10'h000, 0, 0);
    add(0, 0, 10'h008, 0, 10'h000, 0, 0);
    add(0, 1, 10'h008, 0, 10'h008, 3, 1);
    // Requester drops its own request: release, ptr -> 4
    add(0, 1, 10'h000, 0, 10'h000, 0, 0);
    add(0, 1, 10'h000, 0, 10'h000, 0, 0);
    // All three exit conditions at once advance ptr only to 5
    add(0, 1, 10'h030, 0, 10'h010, 4, 1);
    add(0, 0, 10'h000, 1, 10'h000, 0, 0);
    add(0, 1, 10'h030, 0, 10'h000, 0, 0);
    add(0, 1, 10'h030, 0, 10'h020, 5, 1);
    add(0, 1, 10'h030, 1, 10'h000, 0, 0);
    add(0, 1, 10'h000, 0, 10'h000, 0, 0);
    // Reset during grant of id 6 with done high: ptr must return to 0
    add(0, 1, 10'h040, 0, 10'h040, 6, 1);
    add(1, 1, 10'h040, 1, 10'h000, 0, 0);
    add(0, 1, 10'h082, 0, 10'h002, 1, 1);
    add(0, 1, 10'h082, 1, 10'h000, 0, 0);
    add(0, 1, 10'h000, 0, 10'h000, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Held g3817 with done low (ptr is 2 here)
    for (int i = 1; i <= 20; i++) begin
      vec_t v;
      v.rst = 0; v.g35 = 1; v.req = 10'h080; v.done = 0;
      v.gnt = 10'h080; v.id = 7; v.busy = 1; v.tmo = 0;
`ifdef S38584_ARB_TIMEOUT_EN
      if (i == 16 || i == 17) begin
        v.gnt = 10'h000; v.id = 0; v.busy = 0;
        v.tmo = (i == 16);
      end
`endif
      step(v, $sformatf("hold%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
